// File: rtl/ifb_pkg.sv
// Shared definitions for the instruction fetch buffer: opcode/funct codes,
// immediate-extension select codes and the stored-entry layout.
// Latency: n/a (definitions only). Backpressure: n/a.
package ifb_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] SPECIAL = 6'b000000;
    localparam logic [5:0] ANDI    = 6'b001100;
    localparam logic [5:0] ORI     = 6'b001101;
    localparam logic [5:0] XORI    = 6'b001110;
    localparam logic [5:0] LUI     = 6'b001111;

    // SPECIAL funct codes (inst[5:0]) for the constant shifts
    localparam logic [5:0] SLL     = 6'b000000;
    localparam logic [5:0] SRL     = 6'b000010;
    localparam logic [5:0] SRA     = 6'b000011;

    // Immediate-extension select driven to the immediate extender
    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_SHAMT = 2'b10;

    // One buffered fetch: raw pair plus the predecode computed at write time
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  ext_sel;
        logic [15:0] imm16;
        logic [4:0]  shamt;
        logic        adel;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Address-error-on-load check for an instruction fetch: word alignment
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifb_predecode.sv
// Purely combinational predecode of one instruction word into the fields
// the immediate extender consumes. Latency: 0 cycles. Backpressure: none.
// Ports: inst (in, 32) -> ext_sel (2), imm16 (16), shamt (5).
module ifb_predecode
    import ifb_pkg::*;
(
    input  logic [31:0] inst,
    output logic [1:0]  ext_sel,
    output logic [15:0] imm16,
    output logic [4:0]  shamt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    assign imm16  = inst[15:0];
    assign shamt  = inst[10:6];

    // Register specifiers are of no interest to the extender
    assign unused_fields = ^inst[25:16];

    always_comb begin
        ext_sel = EXT_SIGN;
        if (opcode == SPECIAL) begin
            // Only the constant shifts use shamt; variable shifts and the
            // rest of SPECIAL keep the sign-extend default (imm unused there)
            if (funct == SLL || funct == SRL || funct == SRA) begin
                ext_sel = EXT_SHAMT;
            end
        end else if (opcode == ANDI || opcode == ORI ||
                     opcode == XORI || opcode == LUI) begin
            ext_sel = EXT_ZERO;
        end
    end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: queues {PC, instruction} pairs between AXI fetch
// and decode, predecoding each entry on write. Latency: 1 cycle push-to-valid
// (0 cycles into an empty buffer when IFB_BYPASS_EN is defined).
// Backpressure: in_ready = (count < DEPTH), from registered count only.
//
// Optional macro: IFB_BYPASS_EN - empty-buffer combinational bypass.
// Ports:
//   clk, resetn (sync, active-low), flush (drop all entries and same-cycle push/pop)
//   in_valid/in_ready/in_pc/in_inst        : fetch side
//   out_valid/out_ready/out_pc/out_inst    : decode side head entry
//   out_ext_sel/out_imm16/out_shamt        : predecoded immediate info
//   out_adel                               : head PC not word aligned
module inst_fetch_buffer
    import ifb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [1:0]  out_ext_sel,
    output logic [15:0] out_imm16,
    output logic [4:0]  out_shamt,
    output logic        out_adel
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic               empty;
    entry_t             wr_entry;
    entry_t             head_entry;

    logic [1:0]         wr_ext_sel;
    logic [15:0]        wr_imm16;
    logic [4:0]         wr_shamt;

    assign empty    = (count == '0);
    assign in_ready = (count < DEPTH_C);

    // Write-path predecode: result is stored alongside the raw pair
    ifb_predecode u_pre_wr (
        .inst    (in_inst),
        .ext_sel (wr_ext_sel),
        .imm16   (wr_imm16),
        .shamt   (wr_shamt)
    );

    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = in_pc;
        wr_entry.inst    = in_inst;
        wr_entry.ext_sel = wr_ext_sel;
        wr_entry.imm16   = wr_imm16;
        wr_entry.shamt   = wr_shamt;
        wr_entry.adel    = pc_misaligned(in_pc);
    end

`ifdef IFB_BYPASS_EN
    logic   byp_vld;

    // Bypass path gets its own predecode so the write path stays untouched
    // by the output mux; both see the same input word.
    logic [1:0]  byp_ext_sel;
    logic [15:0] byp_imm16;
    logic [4:0]  byp_shamt;
    entry_t      byp_entry;

    ifb_predecode u_pre_byp (
        .inst    (in_inst),
        .ext_sel (byp_ext_sel),
        .imm16   (byp_imm16),
        .shamt   (byp_shamt)
    );

    always_comb begin
        byp_entry         = '0;
        byp_entry.pc      = in_pc;
        byp_entry.inst    = in_inst;
        byp_entry.ext_sel = byp_ext_sel;
        byp_entry.imm16   = byp_imm16;
        byp_entry.shamt   = byp_shamt;
        byp_entry.adel    = pc_misaligned(in_pc);
    end

    assign byp_vld    = empty && in_valid && !flush;
    assign head_entry = byp_vld ? byp_entry : mem[head];
    assign out_valid  = !empty || byp_vld;
    // A bypassed entry that decode takes immediately never touches storage
    assign push       = in_valid && in_ready && !flush && !(byp_vld && out_ready);
`else
    assign head_entry = mem[head];
    assign out_valid  = !empty;
    assign push       = in_valid && in_ready && !flush;
`endif

    // Pop only real stored entries; a consumed bypass entry is not a pop
    assign pop = !empty && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage keeps stale contents; only occupancy and pointers reset
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wr_entry;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_pc      = head_entry.pc;
    assign out_inst    = head_entry.inst;
    assign out_ext_sel = head_entry.ext_sel;
    assign out_imm16   = head_entry.imm16;
    assign out_shamt   = head_entry.shamt;
    assign out_adel    = head_entry.adel;

endmodule
